// File: rtl/sprite_motion_if.sv
// Sprite motion bus: request/wall inputs from the keycode and maze ROM path,
// registered position and status outputs toward the renderer and collision logic.
interface sprite_motion_if #(
  parameter int POS_W = 10
) ();
  logic             pause;
  logic             life_down;
  logic [7:0]       keycode;
  logic [3:0]       wall;        // {T,B,R,L}
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic [POS_W-1:0] size;
  logic [3:0]       last_dir_x;
  logic [3:0]       last_dir_y;
  logic [1:0]       state;

  modport master (
    output pause, life_down, keycode, wall,
    input  pos_x, pos_y, size, last_dir_x, last_dir_y, state
  );

  modport slave (
    input  pause, life_down, keycode, wall,
    output pos_x, pos_y, size, last_dir_x, last_dir_y, state
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Frame-rate maze sprite motion controller with respawn hold and tunnel wrap.
// Optional queued-turn buffer enabled by defining MOTION_TURN_QUEUE_EN.
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   ST_RESPAWN | held at start position, respawn counter running
//   ST_IDLE    | no direction, waiting for an open request
//   ST_MOVING  | stepping each frame in dir
//   ST_FROZEN  | pause high, position and direction held
module sprite_motion_ctrl #(
  parameter int POS_W          = 10,
  parameter int X_START        = 202,
  parameter int Y_START        = 253,
  parameter int X_MAX          = 404,
  parameter int Y_MAX          = 447,
  parameter int SIZE           = 13,
  parameter int STEP           = 1,
  parameter int TUNNEL_Y_LO    = 195,
  parameter int TUNNEL_Y_HI    = 223,
  parameter int TUNNEL_X_LO    = 10,
  parameter int TUNNEL_X_HI    = 390,
  parameter int WRAP_MARGIN    = 5,
  parameter int RESPAWN_FRAMES = 60,
  parameter int QUEUE_FRAMES   = 8
) (
  input  logic frame_clk,
  input  logic Reset,
  sprite_motion_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RESPAWN = 2'd0,
    ST_IDLE    = 2'd1,
    ST_MOVING  = 2'd2,
    ST_FROZEN  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_L    = 3'd1,
    DIR_R    = 3'd2,
    DIR_U    = 3'd3,
    DIR_D    = 3'd4
  } dir_t;

  localparam int RCNT_W = $clog2(RESPAWN_FRAMES + 1);

  localparam logic [POS_W-1:0] X_START_P = POS_W'(X_START);
  localparam logic [POS_W-1:0] Y_START_P = Y_START[POS_W-1:0];
  localparam logic [POS_W-1:0] STEP_P    = POS_W'(STEP);
  localparam logic [POS_W-1:0] SIZE_P    = POS_W'(SIZE);
  localparam logic [POS_W-1:0] TYLO_P    = POS_W'(TUNNEL_Y_LO);
  localparam logic [POS_W-1:0] TYHI_P    = POS_W'(TUNNEL_Y_HI);
  localparam logic [POS_W-1:0] TXLO_P    = POS_W'(TUNNEL_X_LO);
  localparam logic [POS_W-1:0] TXHI_P    = POS_W'(TUNNEL_X_HI);
  localparam logic [POS_W-1:0] WRAP_L_P  = POS_W'(TUNNEL_X_HI - WRAP_MARGIN);
  localparam logic [POS_W-1:0] WRAP_R_P  = POS_W'(TUNNEL_X_LO + WRAP_MARGIN);
  localparam logic [POS_W:0]   SIZE_E    = (POS_W+1)'(SIZE);
  localparam logic [POS_W:0]   XMAX_E    = (POS_W+1)'(X_MAX);
  localparam logic [POS_W:0]   YMAX_E    = (POS_W+1)'(Y_MAX);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESPAWN_FRAMES - 1);

  state_t             state_q, state_d;
  dir_t               dir_q, dir_d;
  logic [POS_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [3:0]         ldx_q, ldx_d, ldy_q, ldy_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
`ifdef MOTION_TURN_QUEUE_EN
  localparam int QCNT_W = $clog2(QUEUE_FRAMES + 1);
  localparam logic [QCNT_W-1:0] QCNT_LOAD = QCNT_W'(QUEUE_FRAMES);
  dir_t               qdir_q, qdir_d;
  logic [QCNT_W-1:0]  qcnt_q, qcnt_d;
`endif

  dir_t               req_dir, try_dir, chosen;
  logic               in_band;
  logic               open_l, open_r, open_u, open_d;
  logic [3:0]         open_v;
  logic [POS_W:0]     px_e, py_e, l_diff, u_diff;

  // ov packs the per-side open flags as {D,U,R,L}
  function automatic logic side_open(input dir_t d, input logic [3:0] ov);
    case (d)
      DIR_L:   return ov[0];
      DIR_R:   return ov[1];
      DIR_U:   return ov[2];
      DIR_D:   return ov[3];
      default: return 1'b0;
    endcase
  endfunction

  // Keycode to direction request decode
  always_comb begin
    req_dir = DIR_NONE;
    case (bus.keycode)
      8'h04:   req_dir = DIR_L;
      8'h07:   req_dir = DIR_R;
      8'h16:   req_dir = DIR_D;
      8'h1A:   req_dir = DIR_U;
      default: req_dir = DIR_NONE;
    endcase
  end

  // Border tests widened by one bit so that pos - SIZE cannot wrap silently
  assign px_e    = {1'b0, pos_x_q};
  assign py_e    = {1'b0, pos_y_q};
  assign l_diff  = px_e - SIZE_E;
  assign u_diff  = py_e - SIZE_E;
  assign in_band = (pos_y_q >= TYLO_P) && (pos_y_q <= TYHI_P);
  assign open_l  = !bus.wall[0] && (in_band || (!l_diff[POS_W] && (l_diff != '0)));
  assign open_r  = !bus.wall[1] && (in_band || ((px_e + SIZE_E) < XMAX_E));
  assign open_u  = !bus.wall[3] && (!u_diff[POS_W] && (u_diff != '0));
  assign open_d  = !bus.wall[2] && ((py_e + SIZE_E) < YMAX_E);
  assign open_v  = {open_d, open_u, open_r, open_l};

  // Next-state, direction choice, stepping and tunnel wrap
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    ldx_d   = ldx_q;
    ldy_d   = ldy_q;
    rcnt_d  = rcnt_q;
    try_dir = DIR_NONE;
    chosen  = DIR_NONE;
`ifdef MOTION_TURN_QUEUE_EN
    qdir_d  = qdir_q;
    qcnt_d  = qcnt_q;
`endif
    if (bus.life_down) begin
      state_d = ST_RESPAWN;
      dir_d   = DIR_NONE;
      pos_x_d = X_START_P;
      pos_y_d = Y_START_P;
      rcnt_d  = '0;
`ifdef MOTION_TURN_QUEUE_EN
      qdir_d  = DIR_NONE;
      qcnt_d  = '0;
`endif
    end else begin
      case (state_q)
        ST_RESPAWN: begin
          if (!bus.pause) begin
            if (rcnt_q == RCNT_LAST) state_d = ST_IDLE;
            else                     rcnt_d  = rcnt_q + 1'b1;
          end
        end
        ST_FROZEN: begin
          if (!bus.pause) state_d = (dir_q != DIR_NONE) ? ST_MOVING : ST_IDLE;
        end
        default: begin
          if (bus.pause) begin
            state_d = ST_FROZEN;
          end else begin
            try_dir = req_dir;
`ifdef MOTION_TURN_QUEUE_EN
            // a live queued turn behaves like a held key
            if (req_dir == DIR_NONE) try_dir = qdir_q;
`endif
            if (try_dir != DIR_NONE && side_open(try_dir, open_v))
              chosen = try_dir;
            else if (dir_q != DIR_NONE && side_open(dir_q, open_v))
              chosen = dir_q;
            else
              chosen = DIR_NONE;
`ifdef MOTION_TURN_QUEUE_EN
            if (req_dir != DIR_NONE) begin
              if (side_open(req_dir, open_v)) begin
                qdir_d = DIR_NONE;
                qcnt_d = '0;
              end else begin
                qdir_d = req_dir;
                qcnt_d = QCNT_LOAD;
              end
            end else if (qdir_q != DIR_NONE) begin
              if (side_open(qdir_q, open_v) || qcnt_q <= 1) begin
                qdir_d = DIR_NONE;
                qcnt_d = '0;
              end else begin
                qcnt_d = qcnt_q - 1'b1;
              end
            end
`endif
            dir_d   = chosen;
            state_d = (chosen != DIR_NONE) ? ST_MOVING : ST_IDLE;
            case (chosen)
              DIR_L: begin
                ldx_d = 4'd1;
                if (in_band && pos_x_q <= TXLO_P) pos_x_d = WRAP_L_P;
                else                              pos_x_d = pos_x_q - STEP_P;
              end
              DIR_R: begin
                ldx_d = 4'd3;
                if (in_band && pos_x_q >= TXHI_P) pos_x_d = WRAP_R_P;
                else                              pos_x_d = pos_x_q + STEP_P;
              end
              DIR_U: begin
                ldy_d   = 4'd1;
                pos_y_d = pos_y_q - STEP_P;
              end
              DIR_D: begin
                ldy_d   = 4'd3;
                pos_y_d = pos_y_q + STEP_P;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // State and datapath registers; Reset also restores last_dir
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= ST_RESPAWN;
      dir_q   <= DIR_NONE;
      pos_x_q <= X_START_P;
      pos_y_q <= Y_START_P;
      ldx_q   <= 4'd2;
      ldy_q   <= 4'd2;
      rcnt_q  <= '0;
`ifdef MOTION_TURN_QUEUE_EN
      qdir_q  <= DIR_NONE;
      qcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      ldx_q   <= ldx_d;
      ldy_q   <= ldy_d;
      rcnt_q  <= rcnt_d;
`ifdef MOTION_TURN_QUEUE_EN
      qdir_q  <= qdir_d;
      qcnt_q  <= qcnt_d;
`endif
    end
  end

  assign bus.pos_x      = pos_x_q;
  assign bus.pos_y      = pos_y_q;
  assign bus.size       = SIZE_P;
  assign bus.last_dir_x = ldx_q;
  assign bus.last_dir_y = ldy_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: directed scenarios then random frames,
// checked against an integer-arithmetic reference model.
module tb_sprite_motion_ctrl;

  localparam int POS_W          = 10;
  localparam int X_START        = 202;
  localparam int Y_START        = 253;
  localparam int X_MAX          = 404;
  localparam int Y_MAX          = 447;
  localparam int SIZE           = 13;
  localparam int STEP           = 1;
  localparam int TUNNEL_Y_LO    = 195;
  localparam int TUNNEL_Y_HI    = 223;
  localparam int TUNNEL_X_LO    = 10;
  localparam int TUNNEL_X_HI    = 390;
  localparam int WRAP_MARGIN    = 5;
  localparam int RESPAWN_FRAMES = 60;
  localparam int QUEUE_FRAMES   = 8;

  logic frame_clk;
  logic Reset;

  sprite_motion_if #(.POS_W(POS_W)) bus ();

  sprite_motion_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  typedef struct {
    int x;
    int y;
    int st;
    int lx;
    int ly;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   frame_no = 0;

  // reference model state
  int mx, my, mdx, mdy, mlx, mly, mst, mcnt;
`ifdef MOTION_TURN_QUEUE_EN
  int qdx, qdy, qlife;
`endif

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic bit m_open(int dx, int dy, logic [3:0] w);
    bit band;
    band = (my >= TUNNEL_Y_LO) && (my <= TUNNEL_Y_HI);
    if (dx < 0) return !w[0] && (band || (mx - SIZE > 0));
    if (dx > 0) return !w[1] && (band || (mx + SIZE < X_MAX));
    if (dy < 0) return !w[3] && (my - SIZE > 0);
    if (dy > 0) return !w[2] && (my + SIZE < Y_MAX);
    return 1'b0;
  endfunction

  task automatic key_dir(input logic [7:0] k, output int dx, output int dy);
    dx = 0;
    dy = 0;
    case (k)
      8'h04:   dx = -1;
      8'h07:   dx = 1;
      8'h16:   dy = 1;
      8'h1A:   dy = -1;
      default: ;
    endcase
  endtask

  task automatic model_step(input logic r, input logic l, input logic p,
                            input logic [7:0] k, input logic [3:0] w);
    int kdx, kdy, tdx, tdy, ndx, ndy;
    bit band;
    if (r || l) begin
      mx = X_START; my = Y_START; mdx = 0; mdy = 0; mst = 0; mcnt = 0;
`ifdef MOTION_TURN_QUEUE_EN
      qlife = 0;
`endif
      if (r) begin mlx = 2; mly = 2; end
    end else if (mst == 0) begin
      if (!p) begin
        if (mcnt == RESPAWN_FRAMES - 1) mst = 1;
        else mcnt++;
      end
    end else if (mst == 3) begin
      if (!p) mst = (mdx != 0 || mdy != 0) ? 2 : 1;
    end else if (p) begin
      mst = 3;
    end else begin
      key_dir(k, kdx, kdy);
      tdx = kdx;
      tdy = kdy;
`ifdef MOTION_TURN_QUEUE_EN
      if (kdx == 0 && kdy == 0 && qlife > 0) begin tdx = qdx; tdy = qdy; end
`endif
      ndx = 0;
      ndy = 0;
      if ((tdx != 0 || tdy != 0) && m_open(tdx, tdy, w)) begin
        ndx = tdx; ndy = tdy;
      end else if ((mdx != 0 || mdy != 0) && m_open(mdx, mdy, w)) begin
        ndx = mdx; ndy = mdy;
      end
`ifdef MOTION_TURN_QUEUE_EN
      if (kdx != 0 || kdy != 0) begin
        if (m_open(kdx, kdy, w)) qlife = 0;
        else begin qdx = kdx; qdy = kdy; qlife = QUEUE_FRAMES; end
      end else if (qlife > 0) begin
        if (m_open(qdx, qdy, w)) qlife = 0;
        else qlife--;
      end
`endif
      band = (my >= TUNNEL_Y_LO) && (my <= TUNNEL_Y_HI);
      if (ndx < 0 && band && mx <= TUNNEL_X_LO)      mx = TUNNEL_X_HI - WRAP_MARGIN;
      else if (ndx > 0 && band && mx >= TUNNEL_X_HI) mx = TUNNEL_X_LO + WRAP_MARGIN;
      else                                           mx = mx + ndx * STEP;
      my = my + ndy * STEP;
      if (ndx != 0) mlx = 2 + ndx;
      if (ndy != 0) mly = 2 + ndy;
      mdx = ndx;
      mdy = ndy;
      mst = (ndx != 0 || ndy != 0) ? 2 : 1;
    end
  endtask

  // One frame: drive inputs, predict the post-edge outputs, queue them, advance
  task automatic frame(input logic r, input logic l, input logic p,
                       input logic [7:0] k, input logic [3:0] w);
    exp_t e;
    Reset         = r;
    bus.life_down = l;
    bus.pause     = p;
    bus.keycode   = k;
    bus.wall      = w;
    model_step(r, l, p, k, w);
    e.x = mx; e.y = my; e.st = mst; e.lx = mlx; e.ly = mly;
    exp_q.push_back(e);
    @(posedge frame_clk);
    #2;
    frame_no++;
  endtask

  task automatic run(input int n, input logic [7:0] k, input logic [3:0] w);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 1'b0, k, w);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s frame %0d: got %0d required %0d", name, frame_no, act, expv);
  endtask

  // Monitor: every frame edge is an output event; compare against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pos_x",      int'(bus.pos_x),      e.x);
        chk("pos_y",      int'(bus.pos_y),      e.y);
        chk("state",      int'(bus.state),      e.st);
        chk("last_dir_x", int'(bus.last_dir_x), e.lx);
        chk("last_dir_y", int'(bus.last_dir_y), e.ly);
        chk("size",       int'(bus.size),       SIZE);
      end
    end
  end

  initial begin
    logic [3:0] w;
    logic [7:0] k;
    int         seg;
    int         r;
    Reset         = 1'b1;
    bus.life_down = 1'b0;
    bus.pause     = 1'b0;
    bus.keycode   = 8'h00;
    bus.wall      = 4'h0;
    mlx = 2; mly = 2;
    #2;

    // reset and respawn hold
    frame(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
    run(RESPAWN_FRAMES + 2, 8'h00, 4'h0);
    // one-frame R key, motion persists, wall on R stops at 250
    run(1, 8'h07, 4'h0);
    run(47, 8'h00, 4'h0);
    run(3, 8'h00, 4'h2);
    run(2, 8'h00, 4'h0);
    // climb into the tunnel band, then run left through the wrap
    run(1, 8'h1A, 4'h0);
    run(42, 8'h00, 4'h0);
    run(1, 8'h04, 4'h0);
    run(300, 8'h00, 4'h0);
    // pause mid-motion then lose a life
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
    frame(1'b0, 1'b1, 1'b1, 8'h00, 4'h0);
    run(RESPAWN_FRAMES, 8'h00, 4'h0);
    // blocked up-turn released 4 frames later, then 9 frames later
    run(1, 8'h07, 4'h0);
    run(5, 8'h00, 4'h0);
    run(1, 8'h1A, 4'h8);
    run(3, 8'h00, 4'h8);
    run(4, 8'h00, 4'h0);
    run(1, 8'h07, 4'h0);
    run(3, 8'h00, 4'h0);
    run(1, 8'h1A, 4'h8);
    run(8, 8'h00, 4'h8);
    run(5, 8'h00, 4'h0);
    frame(1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    run(RESPAWN_FRAMES, 8'h00, 4'h0);
    // drive into all four outer borders
    run(1, 8'h1A, 4'h0);
    run(260, 8'h00, 4'h0);
    run(1, 8'h07, 4'h0);
    run(200, 8'h00, 4'h0);
    run(1, 8'h16, 4'h0);
    run(440, 8'h00, 4'h0);
    run(1, 8'h04, 4'h0);
    run(400, 8'h00, 4'h0);

    // random traffic
    seg = 0;
    w   = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        for (int b = 0; b < 4; b++) w[b] = ($urandom_range(0, 5) == 0);
        seg = $urandom_range(1, 12);
      end
      seg--;
      r = $urandom_range(0, 15);
      case (r)
        0:       k = 8'h04;
        1:       k = 8'h07;
        2:       k = 8'h16;
        3:       k = 8'h1A;
        4:       k = 8'($urandom_range(0, 255));
        default: k = 8'h00;
      endcase
      frame($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 19) == 0, k, w);
    end

    bus.pause = 1'b1;
    repeat (3) @(posedge frame_clk);
    #5;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
